// File: rtl/nonce_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : nonce_scheduler_if
//  Description : Control and status bundle between the host-side job control,
//                the shapool hashing datapath and nonce_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nonce_scheduler_if #(
  parameter int NONCE_WIDTH = 32
);
  // Job control from external_io
  logic                   start;
  logic                   halt;
  logic [NONCE_WIDTH-1:0] nonce_start;
  logic [NONCE_WIDTH-1:0] nonce_end;
  // Datapath handshake with shapool
  logic                   core_success;
  logic                   core_en;
  logic                   core_clear;
  logic [NONCE_WIDTH-1:0] nonce;
  // Job status
  logic                   busy;
  logic                   found;
  logic                   exhausted;
  logic [NONCE_WIDTH-1:0] found_nonce;

  // Side that owns the job: issues commands, observes status
  modport master (
    output start, halt, nonce_start, nonce_end, core_success,
    input  core_en, core_clear, nonce, busy, found, exhausted, found_nonce
  );

  // The scheduler itself
  modport slave (
    input  start, halt, nonce_start, nonce_end, core_success,
    output core_en, core_clear, nonce, busy, found, exhausted, found_nonce
  );
endinterface
`default_nettype wire

// File: rtl/nonce_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : nonce_scheduler
//  Description : Sequences shapool for one job: clear, batch-wise enable,
//                nonce advance over an inclusive (possibly wrapping) range,
//                and re-alignment of the pipelined success flag to the nonce
//                of the previous batch.
//  Revision    : 1.0 - initial release
// ============================================================================
module nonce_scheduler #(
  parameter int NONCE_WIDTH = 32,
  parameter int ROUNDS      = 64
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  nonce_scheduler_if.slave   bus
);

  localparam int                  c_rnd_w    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [c_rnd_w-1:0] c_rnd_last = c_rnd_w'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_RUN       = 3'd2,
    S_DRAIN     = 3'd3,
    S_FOUND     = 3'd4,
    S_EXHAUSTED = 3'd5
  } state_t;

  state_t                 r_state;
  logic [c_rnd_w-1:0]     r_rnd;
  logic [NONCE_WIDTH-1:0] r_end;
  logic [NONCE_WIDTH-1:0] r_prev_nonce;
  logic                   r_primed;
  logic [NONCE_WIDTH-1:0] r_nonce;
  logic [NONCE_WIDTH-1:0] r_found_nonce;
  logic                   r_core_en;
  logic                   r_core_clear;
  logic                   r_busy;
  logic                   r_found;
  logic                   r_exhausted;

  logic                   w_boundary;

  // Last round of the current batch: the only cycle core_success is meaningful
  assign w_boundary = (r_rnd == c_rnd_last);

  // Job sequencer; every output is a register updated here
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_rnd         <= '0;
      r_end         <= '0;
      r_prev_nonce  <= '0;
      r_primed      <= 1'b0;
      r_nonce       <= '0;
      r_found_nonce <= '0;
      r_core_en     <= 1'b0;
      r_core_clear  <= 1'b0;
      r_busy        <= 1'b0;
      r_found       <= 1'b0;
      r_exhausted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          // halt is deliberately not looked at here, so start always wins
          if (bus.start) begin
            r_state      <= S_CLEAR;
            r_nonce      <= bus.nonce_start;
            r_end        <= bus.nonce_end;
            r_found      <= 1'b0;
            r_exhausted  <= 1'b0;
            r_primed     <= 1'b0;
            r_rnd        <= '0;
            r_core_clear <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        S_CLEAR: begin
          r_core_clear <= 1'b0;
          if (bus.halt) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state   <= S_RUN;
            r_core_en <= 1'b1;
          end
        end

        S_RUN, S_DRAIN: begin
          // Boundary results outrank halt; halt outranks plain batch advance
          if (w_boundary && r_primed && bus.core_success) begin
            // Success seen now belongs to the batch before this one
            r_state       <= S_FOUND;
            r_found       <= 1'b1;
            r_found_nonce <= r_prev_nonce;
            r_core_en     <= 1'b0;
            r_busy        <= 1'b0;
            r_prev_nonce  <= r_nonce;
            r_primed      <= 1'b1;
            r_rnd         <= '0;
          end else if (w_boundary && (r_state == S_DRAIN)) begin
            r_state      <= S_EXHAUSTED;
            r_exhausted  <= 1'b1;
            r_core_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_prev_nonce <= r_nonce;
            r_primed     <= 1'b1;
            r_rnd        <= '0;
          end else if (bus.halt) begin
            r_state   <= S_IDLE;
            r_core_en <= 1'b0;
            r_busy    <= 1'b0;
          end else if (w_boundary) begin
            // Last nonce issued: one extra batch flushes its result out
            if (r_nonce == r_end) begin
              r_state <= S_DRAIN;
            end else begin
              r_nonce <= r_nonce + NONCE_WIDTH'(1);
            end
            r_prev_nonce <= r_nonce;
            r_primed     <= 1'b1;
            r_rnd        <= '0;
          end else begin
            r_rnd <= r_rnd + c_rnd_w'(1);
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_core_en    <= 1'b0;
          r_core_clear <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_en     = r_core_en;
  assign bus.core_clear  = r_core_clear;
  assign bus.nonce       = r_nonce;
  assign bus.busy        = r_busy;
  assign bus.found       = r_found;
  assign bus.exhausted   = r_exhausted;
  assign bus.found_nonce = r_found_nonce;

endmodule
`default_nettype wire

// File: tb/tb_nonce_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nonce_scheduler
//  Description : Directed self-checking bench for nonce_scheduler, ROUNDS=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nonce_scheduler;

  localparam int NW = 32;
  localparam int RN = 4;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  nonce_scheduler_if #(.NONCE_WIDTH(NW)) bus ();

  nonce_scheduler #(.NONCE_WIDTH(NW), .ROUNDS(RN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 ns past it
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start for one edge; returns in the CLEAR cycle
  task automatic start_job(input logic [NW-1:0] s, input logic [NW-1:0] e);
    bus.nonce_start = s;
    bus.nonce_end   = e;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL reset_core_en: got %b exp 0", bus.core_en); end
    n_checks++; if (bus.core_clear !== 1'b0) begin n_fail++; $display("FAIL reset_core_clear: got %b exp 0", bus.core_clear); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    n_checks++; if (bus.found !== 1'b0) begin n_fail++; $display("FAIL reset_found: got %b exp 0", bus.found); end
    n_checks++; if (bus.exhausted !== 1'b0) begin n_fail++; $display("FAIL reset_exhausted: got %b exp 0", bus.exhausted); end
    n_checks++; if (bus.nonce !== 32'h0) begin n_fail++; $display("FAIL reset_nonce: got %h exp 0", bus.nonce); end
    n_checks++; if (bus.found_nonce !== 32'h0) begin n_fail++; $display("FAIL reset_found_nonce: got %h exp 0", bus.found_nonce); end
  endtask

  // Success at the boundary of batch 4 reports the nonce of batch 3
  task automatic test_found();
    start_job(32'h10, 32'h1F);
    n_checks++; if (bus.core_clear !== 1'b1) begin n_fail++; $display("FAIL found_clear_pulse: got %b exp 1", bus.core_clear); end
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL found_en_in_clear: got %b exp 0", bus.core_en); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL found_busy_clear: got %b exp 1", bus.busy); end
    n_checks++; if (bus.nonce !== 32'h10) begin n_fail++; $display("FAIL found_nonce_load: got %h exp 10", bus.nonce); end
    tick();
    n_checks++; if (bus.core_en !== 1'b1) begin n_fail++; $display("FAIL found_en_run: got %b exp 1", bus.core_en); end
    n_checks++; if (bus.core_clear !== 1'b0) begin n_fail++; $display("FAIL found_clear_drop: got %b exp 0", bus.core_clear); end
    tick(15);
    n_checks++; if (bus.nonce !== 32'h13) begin n_fail++; $display("FAIL found_batch4_nonce: got %h exp 13", bus.nonce); end
    bus.core_success = 1'b1;
    tick();
    bus.core_success = 1'b0;
    n_checks++; if (bus.found !== 1'b1) begin n_fail++; $display("FAIL found_flag: got %b exp 1", bus.found); end
    n_checks++; if (bus.found_nonce !== 32'h12) begin n_fail++; $display("FAIL found_nonce_value: got %h exp 12", bus.found_nonce); end
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL found_en_off: got %b exp 0", bus.core_en); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL found_busy_off: got %b exp 0", bus.busy); end
    n_checks++; if (bus.exhausted !== 1'b0) begin n_fail++; $display("FAIL found_not_exhausted: got %b exp 0", bus.exhausted); end
  endtask

  // Full range without success: per-batch nonce, enabled-cycle count, exhausted
  task automatic test_range(input logic [NW-1:0] s, input logic [NW-1:0] e,
                            input logic [NW-1:0] exp_n [8], input int nb);
    int en_cnt;
    start_job(s, e);
    tick();
    en_cnt = 0;
    for (int b = 0; b < nb; b++) begin
      n_checks++; if (bus.nonce !== exp_n[b]) begin n_fail++; $display("FAIL range_nonce batch %0d: got %h exp %h", b, bus.nonce, exp_n[b]); end
      for (int r = 0; r < RN; r++) begin
        if (bus.core_en === 1'b1) en_cnt++;
        tick();
      end
    end
    n_checks++; if (en_cnt !== nb * RN) begin n_fail++; $display("FAIL range_en_cycles: got %0d exp %0d", en_cnt, nb * RN); end
    n_checks++; if (bus.exhausted !== 1'b1) begin n_fail++; $display("FAIL range_exhausted: got %b exp 1", bus.exhausted); end
    n_checks++; if (bus.found !== 1'b0) begin n_fail++; $display("FAIL range_found: got %b exp 0", bus.found); end
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL range_en_off: got %b exp 0", bus.core_en); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL range_busy_off: got %b exp 0", bus.busy); end
  endtask

  // First-batch success ignored; DRAIN-boundary success reports the last nonce
  task automatic test_first_batch_and_drain();
    start_job(32'h5, 32'h7);
    tick(4);
    bus.core_success = 1'b1;
    tick();
    bus.core_success = 1'b0;
    n_checks++; if (bus.found !== 1'b0) begin n_fail++; $display("FAIL first_batch_ignored: got %b exp 0", bus.found); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL first_batch_busy: got %b exp 1", bus.busy); end
    n_checks++; if (bus.nonce !== 32'h6) begin n_fail++; $display("FAIL first_batch_advance: got %h exp 6", bus.nonce); end
    tick(11);
    bus.core_success = 1'b1;
    tick();
    bus.core_success = 1'b0;
    n_checks++; if (bus.found !== 1'b1) begin n_fail++; $display("FAIL drain_found: got %b exp 1", bus.found); end
    n_checks++; if (bus.found_nonce !== 32'h7) begin n_fail++; $display("FAIL drain_found_nonce: got %h exp 7", bus.found_nonce); end
    n_checks++; if (bus.exhausted !== 1'b0) begin n_fail++; $display("FAIL drain_not_exhausted: got %b exp 0", bus.exhausted); end
  endtask

  // halt mid-batch aborts; a new start clears and reloads
  task automatic test_halt();
    start_job(32'h40, 32'h50);
    tick(11);
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL halt_en_off: got %b exp 0", bus.core_en); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL halt_busy_off: got %b exp 0", bus.busy); end
    n_checks++; if ({bus.found, bus.exhausted} !== 2'b00) begin n_fail++; $display("FAIL halt_flags: got %b exp 00", {bus.found, bus.exhausted}); end
    n_checks++; if (bus.nonce !== 32'h42) begin n_fail++; $display("FAIL halt_nonce_held: got %h exp 42", bus.nonce); end
    tick(2);
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL halt_stays_idle: got %b exp 0", bus.core_en); end
    start_job(32'h60, 32'h61);
    n_checks++; if (bus.core_clear !== 1'b1) begin n_fail++; $display("FAIL restart_clear: got %b exp 1", bus.core_clear); end
    n_checks++; if (bus.nonce !== 32'h60) begin n_fail++; $display("FAIL restart_nonce: got %h exp 60", bus.nonce); end
    tick();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
  endtask

  // halt coincident with a success boundary still reports the find
  task automatic test_halt_vs_success();
    start_job(32'h70, 32'h7F);
    tick(8);
    bus.halt         = 1'b1;
    bus.core_success = 1'b1;
    tick();
    bus.halt         = 1'b0;
    bus.core_success = 1'b0;
    n_checks++; if (bus.found !== 1'b1) begin n_fail++; $display("FAIL halt_success_found: got %b exp 1", bus.found); end
    n_checks++; if (bus.found_nonce !== 32'h70) begin n_fail++; $display("FAIL halt_success_nonce: got %h exp 70", bus.found_nonce); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL halt_success_busy: got %b exp 0", bus.busy); end
  endtask

  // halt ignored in FOUND; start from FOUND clears flags; reset mid-RUN
  task automatic test_restart_and_reset();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    n_checks++; if (bus.found !== 1'b1) begin n_fail++; $display("FAIL found_ignores_halt: got %b exp 1", bus.found); end
    start_job(32'h80, 32'h81);
    n_checks++; if (bus.found !== 1'b0) begin n_fail++; $display("FAIL start_in_found_flag: got %b exp 0", bus.found); end
    n_checks++; if (bus.core_clear !== 1'b1) begin n_fail++; $display("FAIL start_in_found_clear: got %b exp 1", bus.core_clear); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL start_in_found_busy: got %b exp 1", bus.busy); end
    tick(6);
    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.halt  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    test_reset();
    reset_n = 1'b1;
    tick();
  endtask

  // start and halt together from IDLE: start wins
  task automatic test_start_halt_same_cycle();
    bus.nonce_start = 32'h90;
    bus.nonce_end   = 32'h91;
    bus.start       = 1'b1;
    bus.halt        = 1'b1;
    tick();
    bus.start       = 1'b0;
    bus.halt        = 1'b0;
    n_checks++; if (bus.core_clear !== 1'b1) begin n_fail++; $display("FAIL start_beats_halt_clear: got %b exp 1", bus.core_clear); end
    n_checks++; if (bus.nonce !== 32'h90) begin n_fail++; $display("FAIL start_beats_halt_nonce: got %h exp 90", bus.nonce); end
    tick();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
  endtask

  initial begin
    logic [NW-1:0] exp_n [8];
    n_checks         = 0;
    n_fail           = 0;
    reset_n          = 1'b0;
    bus.start        = 1'b0;
    bus.halt         = 1'b0;
    bus.nonce_start  = '0;
    bus.nonce_end    = '0;
    bus.core_success = 1'b0;
    tick(3);
    test_reset();
    reset_n = 1'b1;
    tick();

    test_found();

    exp_n = '{32'h5, 32'h6, 32'h7, 32'h7, 32'h0, 32'h0, 32'h0, 32'h0};
    test_range(32'h5, 32'h7, exp_n, 4);

    exp_n = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0};
    test_range(32'hFFFFFFFE, 32'h00000001, exp_n, 5);

    exp_n = '{32'hA5, 32'hA5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    test_range(32'hA5, 32'hA5, exp_n, 2);

    test_first_batch_and_drain();
    test_halt();
    test_halt_vs_success();
    test_restart_and_reset();
    test_start_halt_same_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nonce_scheduler.md
# nonce_scheduler

Sequences the shapool hashing datapath for one job. It clears the pool, enables it batch by batch, advances the nonce across a host-supplied range, and pairs each success with the nonce that produced it. The hashes are pipelined (double SHA), so success at the end of batch k refers to batch k−1; this block removes that offset so the host no longer has to. It sits between external_io (start/halt) and shapool (enable/clear/nonce/success).

## Interface
- NONCE_WIDTH, 32: width of nonce, range bounds and result.
- ROUNDS, 64: clk cycles per batch; must be ≥ 2. Round counter width is clog2(ROUNDS).

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous, active-low reset; clock clk
- start  in  1  pulse; begins a job from IDLE, FOUND or EXHAUSTED
- halt  in  1  level; aborts an active job
- nonce_start  in  NONCE_WIDTH  first nonce, sampled in the start cycle
- nonce_end  in  NONCE_WIDTH  last nonce, inclusive, sampled in the start cycle
- core_success  in  1  shapool success, sampled only on the last round of a batch
- core_en  out  1  shapool enable
- core_clear  out  1  one-cycle pipeline clear pulse
- nonce  out  NONCE_WIDTH  nonce currently fed to shapool
- busy  out  1  high in CLEAR, RUN and DRAIN
- found  out  1  sticky; a success was detected
- exhausted  out  1  sticky; the range completed with no success
- found_nonce  out  NONCE_WIDTH  corrected winning nonce; valid while found=1

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, FOUND, EXHAUSTED.
- Internal registers: round counter `rnd`, end latch `end_r`, `prev_nonce`, pipeline-fill flag `primed`.
- IDLE/FOUND/EXHAUSTED + start → CLEAR.
  - nonce ← nonce_start, end_r ← nonce_end.
  - found, exhausted, primed ← 0; rnd ← 0.
- CLEAR: lasts exactly 1 cycle with core_clear=1, then → RUN.
- RUN and DRAIN: core_en=1; rnd increments each cycle.
- The batch boundary is the cycle where rnd == ROUNDS−1. Actions at the boundary, in priority order:
  1. primed && core_success → FOUND; found ← 1, found_nonce ← prev_nonce.
  2. Otherwise, in DRAIN → EXHAUSTED; exhausted ← 1.
  3. Otherwise, in RUN with nonce == end_r → DRAIN; nonce is held.
  4. Otherwise, in RUN → stay in RUN; nonce ← nonce + 1, modulo 2^NONCE_WIDTH, so all-ones wraps to 0.
  - At every boundary: prev_nonce ← nonce, primed ← 1, rnd ← 0.
- core_success while primed=0 (first batch) is ignored.
- halt=1 in CLEAR, RUN or DRAIN → IDLE. found and exhausted stay 0; nonce holds its value.
- A boundary result (FOUND or EXHAUSTED) takes priority over a simultaneous halt.
- halt is ignored in IDLE, FOUND and EXHAUSTED.
- start is ignored while busy.
- start and halt in the same cycle from IDLE: start wins.
- nonce_start == nonce_end: one RUN batch, then DRAIN.
- Range wraps when nonce_end < nonce_start.
- Any other state encoding → IDLE.

## Timing
- All outputs are registered.
- Reset values: state IDLE; core_en 0, core_clear 0, busy 0, found 0, exhausted 0; nonce 0, found_nonce 0; internal registers 0.
- reset_n low mid-job: all of the above take effect at the next clk edge, regardless of start or halt.
- Start to first enabled cycle:
  - start at edge t → core_clear=1 during cycle t+1.
  - core_en=1 from t+2.
- A job over N nonces with no success runs (N+1)·ROUNDS enabled cycles: N RUN batches plus 1 DRAIN batch.
- exhausted rises the cycle after the last DRAIN cycle; core_en falls on the same edge.
- FOUND: found and found_nonce update, and core_en falls, on the edge after the boundary cycle.
- nonce changes only at boundary edges, or at the start edge.
- halt in cycle t → core_en=0 and busy=0 from t+1.

## Test plan
- ROUNDS=4, start 0x10, end 0x1F; core_success at the boundary of batch 4 → found=1, found_nonce=0x12, core_en=0 on the next edge, busy=0.
- start 5, end 7, no success → nonces 5, 6, 7, 7 (DRAIN); exhausted=1 after 16 enabled cycles; found=0.
- core_success at the first-batch boundary only → ignored, job continues. core_success at the DRAIN boundary with end=7 → found_nonce=7.
- Wrap: start 0xFFFFFFFE, end 0x00000001 → nonces FFFFFFFE, FFFFFFFF, 0, 1, 1 (DRAIN), then exhausted.
- halt at round 2 of batch 3 → IDLE next cycle, core_en=0, found=exhausted=0. A new start → core_clear pulse, nonce=nonce_start. Also check halt coincident with a success boundary → FOUND.
- reset_n low mid-RUN → all outputs at their reset values on the next edge. A start pulse in FOUND → flags cleared, CLEAR entered.
